// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache between the CPU load/store
// stage and a 128-bit block memory with a read/write/busywait handshake.
module dcache_controller #(
    parameter int INDEX_BITS = 3
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         read,
    input  logic         write,
    input  logic [31:0]  address,
    input  logic [31:0]  writedata,
    output logic [31:0]  readdata,
    output logic         busywait,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_address,
    output logic [127:0] mem_writedata,
    input  logic [127:0] mem_readdata,
    input  logic         mem_busywait
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 28 - INDEX_BITS;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WRITEBACK = 2'd1;
    localparam logic [1:0] S_ALLOCATE  = 2'd2;
    localparam logic [1:0] S_UPDATE    = 2'd3;

    logic [1:0]       state;
    logic             started;
    logic [LINES-1:0] valid;
    logic [LINES-1:0] dirty;
    logic [TAG_W-1:0] tag_mem [LINES];
    logic [127:0]     data_mem [LINES];
    logic [127:0]     fetch_buf;

    logic [INDEX_BITS-1:0] index;
    logic [TAG_W-1:0]      tag_in;
    logic [1:0]            offset;
    logic [127:0]          line_data;
    logic                  req;
    logic                  hit;
    logic                  done;
    logic                  unused_addr_bits;

    assign index            = address[3+INDEX_BITS:4];
    assign tag_in           = address[31:4+INDEX_BITS];
    assign offset           = address[3:2];
    assign unused_addr_bits = &{1'b0, address[1:0]};
    assign line_data        = data_mem[index];
    assign req              = read | write;
    assign hit              = valid[index] && (tag_mem[index] == tag_in);

    // Memory handshake: a request is held until mem_busywait has been seen high
    // once (started); the first cycle after that with mem_busywait low is done,
    // and the request drops in that same cycle so the memory never resamples it.
    assign done = started && !mem_busywait;

    always_comb begin
        busywait      = 1'b0;
        readdata      = '0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = '0;
        mem_writedata = '0;
        case (state)
            S_IDLE: begin
                busywait = req && !hit;
                if (read && !write && hit) readdata = line_data[{offset, 5'b0} +: 32];
            end
            S_WRITEBACK: begin
                busywait      = 1'b1;
                mem_write     = !done;
                mem_address   = {tag_mem[index], index};
                mem_writedata = line_data;
            end
            S_ALLOCATE: begin
                busywait    = 1'b1;
                mem_read    = !done;
                mem_address = address[31:4];
            end
            default: busywait = 1'b1;
        endcase
        // A request held across reset must not stall the CPU.
        if (!reset) busywait = 1'b0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            started   <= 1'b0;
            valid     <= '0;
            dirty     <= '0;
            fetch_buf <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        if (hit) begin
                            if (write) dirty[index] <= 1'b1;
                        end else begin
                            state <= (valid[index] && dirty[index]) ? S_WRITEBACK : S_ALLOCATE;
                        end
                    end
                end
                S_WRITEBACK, S_ALLOCATE: begin
                    if (done) begin
                        started <= 1'b0;
                        if (state == S_ALLOCATE) begin
                            fetch_buf <= mem_readdata;
                            state     <= S_UPDATE;
                        end else begin
                            state <= S_ALLOCATE;
                        end
                    end else if (mem_busywait) begin
                        started <= 1'b1;
                    end
                end
                S_UPDATE: begin
                    valid[index] <= 1'b1;
                    dirty[index] <= 1'b0;
                    state        <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Line storage needs no reset: valid gates every use, and reset forces IDLE
    // so neither write path below can fire while reset is low.
    always_ff @(posedge clock) begin
        if (state == S_UPDATE) begin
            data_mem[index] <= fetch_buf;
            tag_mem[index]  <= tag_in;
        end else if (state == S_IDLE && write && hit) begin
            data_mem[index][{offset, 5'b0} +: 32] <= writedata;
        end
    end
endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a behavioural block memory whose
// busy time and busywait rise delay are set per step.
module tb_dcache_controller;
    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         read = 1'b0;
    logic         write = 1'b0;
    logic [31:0]  address = '0;
    logic [31:0]  writedata = '0;
    logic [31:0]  readdata;
    logic         busywait;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_address;
    logic [127:0] mem_writedata;
    logic [127:0] mem_readdata = '0;
    logic         mem_busywait = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // Memory model controls and observations
    int           busy_cycles = 5;
    int           rise_delay  = 0;
    logic [127:0] rd_block    = '0;
    int           xfer_count  = 0;
    logic         in_xfer     = 1'b0;
    logic         is_write    = 1'b0;
    int           busy_cnt    = 0;
    int           dly         = 0;
    logic [27:0]  wb_addr     = '0;
    logic [127:0] wb_data     = '0;
    int           x0;

    dcache_controller dut (
        .clock(clock), .reset(reset), .read(read), .write(write),
        .address(address), .writedata(writedata), .readdata(readdata),
        .busywait(busywait), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_writedata(mem_writedata),
        .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (!reset) begin
            in_xfer      <= 1'b0;
            mem_busywait <= 1'b0;
        end else if (!in_xfer) begin
            if (mem_read || mem_write) begin
                in_xfer    <= 1'b1;
                xfer_count <= xfer_count + 1;
                is_write   <= mem_write;
                busy_cnt   <= busy_cycles;
                dly        <= rise_delay;
                if (mem_write) begin
                    wb_addr <= mem_address;
                    wb_data <= mem_writedata;
                end
                if (rise_delay == 0) mem_busywait <= 1'b1;
            end
        end else if (!mem_busywait) begin
            if (dly <= 1) mem_busywait <= 1'b1;
            dly <= dly - 1;
        end else begin
            if (busy_cnt <= 1) begin
                mem_busywait <= 1'b0;
                in_xfer      <= 1'b0;
                if (!is_write) mem_readdata <= rd_block;
            end else begin
                busy_cnt <= busy_cnt - 1;
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // sel: 0 busywait, 1 mem_read, 2 mem_busywait
    task automatic wait_for(input int sel, input logic level, input int max_cycles, input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            @(negedge clock); #1;
            case (sel)
                0:       seen = (busywait === level);
                1:       seen = (mem_read === level);
                default: seen = (mem_busywait === level);
            endcase
        end
        check(tag, {127'b0, seen}, 128'd1);
    endtask

    initial begin
        // Reset with a pending read: everything quiet
        read = 1'b1; address = 32'h14;
        #1;
        check("rst_busywait", busywait, 0);
        check("rst_mem_read", mem_read, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_mem_address", mem_address, 0);
        check("rst_mem_writedata", mem_writedata, 0);
        check("rst_readdata", readdata, 0);
        @(negedge clock); read = 1'b0; reset = 1'b1;

        // Clean read miss to 0x14
        busy_cycles = 5; rise_delay = 0;
        rd_block = 128'h44444444_33333333_22222222_11111111;
        x0 = xfer_count;
        @(negedge clock); read = 1'b1; address = 32'h14; #1;
        check("miss1_busywait", busywait, 1);
        @(negedge clock); #1;
        check("miss1_mem_read", mem_read, 1);
        check("miss1_mem_address", mem_address, 28'h0000001);
        check("miss1_no_mem_write", mem_write, 0);
        wait_for(0, 1'b0, 30, "miss1_complete");
        check("miss1_readdata", readdata, 32'h22222222);
        check("miss1_xfers", 128'(xfer_count - x0), 1);

        // Hit on the same line, zero wait
        @(negedge clock); address = 32'h10; #1;
        check("hit_readdata", readdata, 32'h11111111);
        check("hit_busywait", busywait, 0);
        check("hit_no_mem_read", mem_read, 0);

        // Write hit, then read it back
        x0 = xfer_count;
        @(negedge clock); read = 1'b0; write = 1'b1; address = 32'h18; writedata = 32'hDEADBEEF; #1;
        check("wr_hit_busywait", busywait, 0);
        check("wr_hit_no_mem_write", mem_write, 0);
        check("wr_hit_no_mem_read", mem_read, 0);
        @(negedge clock); write = 1'b0; read = 1'b1; #1;
        check("wr_readback", readdata, 32'hDEADBEEF);
        check("wr_readback_busywait", busywait, 0);
        check("wr_hit_xfers", 128'(xfer_count - x0), 0);

        // Dirty conflict miss: writeback then allocate
        busy_cycles = 3;
        rd_block = 128'h93939393_92929292_91919191_90909090;
        x0 = xfer_count;
        @(negedge clock); address = 32'h90; #1;
        check("dirty_busywait", busywait, 1);
        @(negedge clock); #1;
        check("wb_mem_write", mem_write, 1);
        check("wb_no_mem_read", mem_read, 0);
        check("wb_mem_address", mem_address, 28'h0000001);
        check("wb_mem_writedata", mem_writedata, 128'h44444444_DEADBEEF_22222222_11111111);
        wait_for(1, 1'b1, 30, "wb_then_mem_read");
        check("alloc_mem_address", mem_address, 28'h0000009);
        check("alloc_no_mem_write", mem_write, 0);
        wait_for(0, 1'b0, 30, "dirty_complete");
        check("dirty_readdata", readdata, 32'h90909090);
        check("dirty_xfers", 128'(xfer_count - x0), 2);
        check("wb_seen_addr", wb_addr, 28'h0000001);
        check("wb_seen_data", wb_data, 128'h44444444_DEADBEEF_22222222_11111111);

        // Dirty the line at index 1 for the reset step
        @(negedge clock); read = 1'b0; write = 1'b1; address = 32'h94; writedata = 32'h12345678; #1;
        check("redirty_busywait", busywait, 0);
        @(negedge clock); write = 1'b0;

        // Memory busywait rises two cycles after the request
        busy_cycles = 3; rise_delay = 2;
        rd_block = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
        x0 = xfer_count;
        @(negedge clock); read = 1'b1; address = 32'h20; #1;
        @(negedge clock); #1;
        check("slow_req_c0", {mem_read, mem_busywait}, 2'b10);
        @(negedge clock); #1;
        check("slow_req_c1", {mem_read, mem_busywait}, 2'b10);
        @(negedge clock); #1;
        check("slow_req_c2", {mem_read, mem_busywait}, 2'b10);
        wait_for(2, 1'b1, 10, "slow_busy_rise");
        wait_for(2, 1'b0, 10, "slow_busy_fall");
        check("slow_done_req_low", mem_read, 0);
        check("slow_done_busywait", busywait, 1);
        wait_for(0, 1'b0, 10, "slow_complete");
        check("slow_readdata", readdata, 32'hA0A0A0A0);
        check("slow_xfers", 128'(xfer_count - x0), 1);
        rise_delay = 0;

        // Write miss allocates, then merges the word
        busy_cycles = 2;
        rd_block = 128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0;
        x0 = xfer_count;
        @(negedge clock); read = 1'b0; write = 1'b1; address = 32'h44; writedata = 32'hCAFEF00D; #1;
        check("wmiss_busywait", busywait, 1);
        wait_for(0, 1'b0, 20, "wmiss_complete");
        @(negedge clock); write = 1'b0; read = 1'b1; #1;
        check("wmiss_merged", readdata, 32'hCAFEF00D);
        @(negedge clock); address = 32'h40; #1;
        check("wmiss_word0", readdata, 32'hC0C0C0C0);
        check("wmiss_xfers", 128'(xfer_count - x0), 1);

        // Reset in the middle of ALLOCATE
        busy_cycles = 5;
        rd_block = 128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0;
        @(negedge clock); address = 32'h30; #1;
        wait_for(1, 1'b1, 10, "rst_alloc_req");
        @(negedge clock); #1;
        reset = 1'b0; #1;
        check("midrst_mem_read", mem_read, 0);
        check("midrst_busywait", busywait, 0);
        check("midrst_mem_address", mem_address, 0);
        check("midrst_readdata", readdata, 0);
        @(negedge clock); read = 1'b0;
        @(negedge clock); reset = 1'b1;

        // Dirty line at index 1 was discarded: plain allocate, no writeback
        rd_block = 128'hE3E3E3E3_E2E2E2E2_E1E1E1E1_E0E0E0E0;
        x0 = xfer_count;
        @(negedge clock); read = 1'b1; address = 32'h10; #1;
        check("post_rst_busywait", busywait, 1);
        @(negedge clock); #1;
        check("post_rst_mem_read", mem_read, 1);
        check("post_rst_no_mem_write", mem_write, 0);
        check("post_rst_mem_address", mem_address, 28'h0000001);
        wait_for(0, 1'b0, 30, "post_rst_complete");
        check("post_rst_readdata", readdata, 32'hE0E0E0E0);
        check("post_rst_xfers", 128'(xfer_count - x0), 1);

        @(negedge clock); read = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate data cache between the CPU load/store stage and the 128-bit block data memory.
- Serves 32-bit word accesses from the CPU.
- On a miss, writes back the dirty victim block, then fetches the new 16-byte block using the memory's read/write/busywait handshake.
- Stalls the CPU via busywait until the access completes.

Parameters:
- INDEX_BITS, 3, log2 of line count (8 lines); tag width = 28 - INDEX_BITS.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- read  in  1  CPU load request
- write  in  1  CPU store request
- address  in  32  CPU byte address; [1:0] ignored, [3:2] word offset, [3+INDEX_BITS:4] index, [31:4+INDEX_BITS] tag
- writedata  in  32  CPU store data
- readdata  out  32  CPU load data
- busywait  out  1  CPU stall
- mem_read  out  1  block read request to data memory
- mem_write  out  1  block write request to data memory
- mem_address  out  28  block address to data memory
- mem_writedata  out  128  victim block; word n on bits [32n+31:32n]
- mem_readdata  in  128  fetched block, same packing
- mem_busywait  in  1  data memory busy

Behaviour:
- Storage per line: valid, dirty, tag, 128-bit data. Reset (reset low, asynchronous) clears all valid and dirty bits, state to IDLE, started flag to 0.
- Outputs while reset is low: busywait=0, mem_read=0, mem_write=0, mem_address=0, mem_writedata=0, readdata=0.
- hit = valid[index] && tag[index]==address tag.
- State IDLE, read hit:
  - readdata = selected word, combinational.
  - busywait=0 in the same cycle; zero-wait.
- State IDLE, write hit:
  - busywait=0.
  - At the posedge, the selected word is written and dirty[index] is set.
- State IDLE, read or write miss:
  - busywait=1 combinationally.
  - Next state is WRITEBACK if valid[index] && dirty[index], else ALLOCATE.
- Simultaneous read and write: treated as a write; readdata is don't-care.
- State WRITEBACK:
  - mem_address = {stored tag, index}.
  - mem_writedata = stored line data.
  - mem_write=1.
- State ALLOCATE:
  - mem_address = address[31:4].
  - mem_read=1.
- Memory handshake, in WRITEBACK and ALLOCATE:
  - The request stays high until mem_busywait has been seen high at least once (started flag set at a posedge with mem_busywait=1).
  - Done = started && !mem_busywait.
  - mem_read and mem_write are combinational: forced to 0 in the cycle done is true, so the memory does not resample the request.
  - At that posedge, started is cleared and the state advances: WRITEBACK->ALLOCATE, ALLOCATE->UPDATE.
  - No timeout; the controller waits indefinitely.
- State UPDATE:
  - Line data = mem_readdata (captured at the ALLOCATE done edge), tag updated, valid=1, dirty=0.
  - busywait=1; next state IDLE.
  - The pending access then hits in IDLE and completes (read returns word; write merges word and sets dirty).
- Miss latency: clean miss = memory read time + 2 cycles; dirty miss adds memory write time + 1 cycle.
- busywait is 1 in every state except IDLE-with-hit and IDLE-with-no-request.
- CPU must hold read, write, address and writedata stable while busywait=1. A change mid-miss is undefined except reset.
- Reset mid-operation:
  - Abandons the transfer immediately.
  - No partial line update.
  - All lines invalid afterwards, including any dirty data.

Test Plan:
- Reset, then read 0x00000014; memory model returns 0x44444444_33333333_22222222_11111111 after 5 busy cycles.
  - Expect busywait=1, mem_read=1, mem_address=0x0000001, no mem_write.
  - Then readdata=0x22222222 with busywait=0.
- Next cycle read 0x00000010 -> readdata=0x11111111, busywait=0 same cycle, mem_read stays 0.
- Write 0x00000018 data 0xDEADBEEF -> busywait=0, no memory traffic; then read 0x00000018 returns 0xDEADBEEF.
- Read 0x00000090 (same index 1, tag 1):
  - Expect mem_write with mem_address=0x0000001.
  - mem_writedata=0x44444444_DEADBEEF_22222222_11111111.
  - Then mem_read with mem_address=0x0000009, then readdata = word 0 of the returned block.
- Memory model delays mem_busywait rise by 2 cycles after request -> mem_read held high until busywait is seen; exactly one transfer; no early completion.
- Drop reset during ALLOCATE -> mem_read=0 and busywait=0 immediately.
  - After release, read 0x00000010 misses again with mem_read and no writeback.
